// File: rtl/app_state_pkg.sv
// Shared app/screen state encodings and menu codes for the sequencer and the
// OLED/7-segment output mux.
package app_state_pkg;

    typedef enum logic [3:0] {
        ST_MENU        = 4'b0000,
        ST_VOLUME      = 4'b0001,
        ST_POKEMON     = 4'b0010,
        ST_POKE_OVER   = 4'b0011,
        ST_FRUIT       = 4'b0100,
        ST_POTION      = 4'b0101,
        ST_LOADING     = 4'b0110,
        ST_POTION_OVER = 4'b0111,
        ST_POTION_WIN  = 4'b1000,
        ST_LOCKED      = 4'b1111
    } app_state_e;

    localparam int unsigned LOAD_STEPS = 96;

    localparam logic [1:0] SEL_VOLUME  = 2'd0;
    localparam logic [1:0] SEL_POKEMON = 2'd1;
    localparam logic [1:0] SEL_FRUIT   = 2'd2;
    localparam logic [1:0] SEL_POTION  = 2'd3;

    // Game reached after the loading screen for a given menu cursor value.
    function automatic app_state_e sel_to_game(input logic [1:0] sel);
        case (sel)
            SEL_POKEMON: return ST_POKEMON;
            SEL_FRUIT:   return ST_FRUIT;
            SEL_POTION:  return ST_POTION;
            default:     return ST_VOLUME;
        endcase
    endfunction

    function automatic logic is_hold_state(input app_state_e s);
        case (s)
            ST_POKE_OVER, ST_POTION_OVER, ST_POTION_WIN: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/app_state_sequencer_cycle_timer.sv
// Shared cycle counter: counts 0..limit while enabled, wraps at limit, and is
// held at zero when cleared or disabled.
module cycle_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    assign done  = en && (r_count == limit);
    assign count = r_count;

    // Next count value: clear has priority, the wrap at limit restarts from zero.
    always_comb begin
        w_count_nxt = '0;
        if (clr) begin
            w_count_nxt = '0;
        end else if (en && !done) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else begin
            w_count_nxt = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: rtl/app_state_sequencer.sv
// Top-level application controller: lock/unlock, menu, timed loading screen,
// game-over/win hold screens and the one-cycle game start pulse.
module app_state_sequencer
    import app_state_pkg::*;
#(
    parameter int unsigned LOAD_STEP   = 1_041_667,
    parameter int unsigned HOLD_CYCLES = 300_000_000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       unlock_ok,
    input  logic       lock_req,
    input  logic       btn_c,
    input  logic       btn_l,
    input  logic [1:0] menu_sel,
    input  logic       pokemon_over,
    input  logic       potion_over,
    input  logic       potion_win,
    output logic [3:0] state,
    output logic [6:0] load_progress,
    output logic       game_start
);

    localparam logic [CNT_W-1:0] LOAD_LIM = CNT_W'(LOAD_STEP - 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES - 1);

    app_state_e       r_state;
    app_state_e       w_next_state;
    app_state_e       r_target;
    app_state_e       w_next_target;
    logic [6:0]       r_progress;
    logic [6:0]       w_next_progress;
    logic             r_start;
    logic             w_next_start;

    logic             w_timer_en;
    logic             w_timer_clr;
    logic             w_timer_done;
    logic [CNT_W-1:0] w_timer_limit;
    logic [CNT_W-1:0] w_timer_count;
    logic             w_unused_count;

    assign state          = r_state;
    assign load_progress  = r_progress;
    assign game_start     = r_start;
    assign w_unused_count = ^w_timer_count;

    // Timer runs only in LOADING and the hold screens; any state change restarts it.
    always_comb begin
        w_timer_en    = (r_state == ST_LOADING) || is_hold_state(r_state);
        w_timer_limit = (r_state == ST_LOADING) ? LOAD_LIM : HOLD_LIM;
        w_timer_clr   = (w_next_state != r_state);
    end

    cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_timer_clr),
        .en    (w_timer_en),
        .limit (w_timer_limit),
        .done  (w_timer_done),
        .count (w_timer_count)
    );

    // Next-state, target, progress and start-pulse decode.
    always_comb begin
        w_next_state    = r_state;
        w_next_target   = r_target;
        w_next_progress = r_progress;
        w_next_start    = 1'b0;

        if (lock_req && (r_state != ST_LOCKED)) begin
            w_next_state    = ST_LOCKED;
            w_next_progress = 7'd0;
        end else begin
            case (r_state)
                ST_LOCKED: begin
                    if (unlock_ok) begin
                        w_next_state    = ST_MENU;
                        w_next_progress = 7'd0;
                    end else begin
                        w_next_state = ST_LOCKED;
                    end
                end
                ST_MENU: begin
                    if (btn_c && (menu_sel == SEL_VOLUME)) begin
                        w_next_state = ST_VOLUME;
                        w_next_start = 1'b1;
                    end else if (btn_c) begin
                        w_next_state    = ST_LOADING;
                        w_next_target   = sel_to_game(menu_sel);
                        w_next_progress = 7'd0;
                    end else begin
                        w_next_state = ST_MENU;
                    end
                end
                ST_LOADING: begin
                    if (w_timer_done && (r_progress == 7'(LOAD_STEPS - 1))) begin
                        w_next_state    = r_target;
                        w_next_progress = 7'(LOAD_STEPS);
                        w_next_start    = 1'b1;
                    end else if (w_timer_done) begin
                        w_next_progress = r_progress + 7'd1;
                    end else begin
                        w_next_progress = r_progress;
                    end
                end
                ST_VOLUME, ST_FRUIT: begin
                    if (btn_l) begin
                        w_next_state    = ST_MENU;
                        w_next_progress = 7'd0;
                    end else begin
                        w_next_state = r_state;
                    end
                end
                ST_POKEMON: begin
                    if (pokemon_over) begin
                        w_next_state = ST_POKE_OVER;
                    end else if (btn_l) begin
                        w_next_state    = ST_MENU;
                        w_next_progress = 7'd0;
                    end else begin
                        w_next_state = ST_POKEMON;
                    end
                end
                ST_POTION: begin
                    // A win reported together with a loss counts as a win.
                    if (potion_win) begin
                        w_next_state = ST_POTION_WIN;
                    end else if (potion_over) begin
                        w_next_state = ST_POTION_OVER;
                    end else if (btn_l) begin
                        w_next_state    = ST_MENU;
                        w_next_progress = 7'd0;
                    end else begin
                        w_next_state = ST_POTION;
                    end
                end
                ST_POKE_OVER, ST_POTION_OVER, ST_POTION_WIN: begin
                    if (w_timer_done || btn_c) begin
                        w_next_state    = ST_MENU;
                        w_next_progress = 7'd0;
                    end else begin
                        w_next_state = r_state;
                    end
                end
                default: begin
                    w_next_state    = ST_MENU;
                    w_next_progress = 7'd0;
                end
            endcase
        end
    end

    // State, target and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_LOCKED;
            r_target   <= ST_MENU;
            r_progress <= 7'd0;
            r_start    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_target   <= w_next_target;
            r_progress <= w_next_progress;
            r_start    <= w_next_start;
        end
    end

endmodule

// File: tb/tb_app_state_sequencer.sv
// Bench for app_state_sequencer: directed scenarios plus randomized pulses,
// all checked against a time-in-state reference model.
module tb_app_state_sequencer;
    import app_state_pkg::*;

    localparam int unsigned LS = 2;
    localparam int unsigned HC = 10;

    localparam logic [3:0] M_MENU        = 4'h0;
    localparam logic [3:0] M_VOLUME      = 4'h1;
    localparam logic [3:0] M_POKEMON     = 4'h2;
    localparam logic [3:0] M_POKE_OVER   = 4'h3;
    localparam logic [3:0] M_FRUIT       = 4'h4;
    localparam logic [3:0] M_POTION      = 4'h5;
    localparam logic [3:0] M_LOADING     = 4'h6;
    localparam logic [3:0] M_POTION_OVER = 4'h7;
    localparam logic [3:0] M_POTION_WIN  = 4'h8;
    localparam logic [3:0] M_LOCKED      = 4'hF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       unlock_ok, lock_req, btn_c, btn_l;
    logic [1:0] menu_sel;
    logic       pokemon_over, potion_over, potion_win;
    logic [3:0] state;
    logic [6:0] load_progress;
    logic       game_start;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_state, m_target;
    int         m_prog, m_elapsed;
    logic       m_start;

    app_state_sequencer #(
        .LOAD_STEP   (LS),
        .HOLD_CYCLES (HC),
        .CNT_W       (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .unlock_ok     (unlock_ok),
        .lock_req      (lock_req),
        .btn_c         (btn_c),
        .btn_l         (btn_l),
        .menu_sel      (menu_sel),
        .pokemon_over  (pokemon_over),
        .potion_over   (potion_over),
        .potion_win    (potion_win),
        .state         (state),
        .load_progress (load_progress),
        .game_start    (game_start)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state   = M_LOCKED;
        m_target  = M_MENU;
        m_prog    = 0;
        m_elapsed = 0;
        m_start   = 1'b0;
    endtask

    // One clock edge of the reference model; m_elapsed = edges spent in the current state.
    task automatic model_step(input logic uo, lr, bc, bl, input logic [1:0] sel,
                              input logic po, pto, ptw);
        logic [3:0] nxt;
        logic       st;
        nxt = m_state;
        st  = 1'b0;
        if (lr && m_state != M_LOCKED) nxt = M_LOCKED;
        else begin
            case (m_state)
                M_LOCKED:  if (uo) nxt = M_MENU;
                M_MENU: begin
                    if (bc && sel == 2'd0) begin
                        nxt = M_VOLUME;
                        st  = 1'b1;
                    end else if (bc) begin
                        m_target = (sel == 2'd1) ? M_POKEMON : (sel == 2'd2) ? M_FRUIT : M_POTION;
                        nxt      = M_LOADING;
                    end
                end
                M_LOADING: begin
                    if (m_elapsed + 1 == LS * 96) begin
                        nxt = m_target;
                        st  = 1'b1;
                    end
                end
                M_VOLUME, M_FRUIT: if (bl) nxt = M_MENU;
                M_POKEMON: begin
                    if (po) nxt = M_POKE_OVER;
                    else if (bl) nxt = M_MENU;
                end
                M_POTION: begin
                    if (ptw) nxt = M_POTION_WIN;
                    else if (pto) nxt = M_POTION_OVER;
                    else if (bl) nxt = M_MENU;
                end
                M_POKE_OVER, M_POTION_OVER, M_POTION_WIN:
                    if (bc || m_elapsed + 1 == HC) nxt = M_MENU;
                default: nxt = M_MENU;
            endcase
        end
        if (nxt == M_MENU || nxt == M_LOCKED) m_prog = 0;
        else if (nxt == M_LOADING && m_state != M_LOADING) m_prog = 0;
        else if (m_state == M_LOADING) m_prog = (m_elapsed + 1) / LS;
        m_elapsed = (nxt != m_state) ? 0 : m_elapsed + 1;
        m_state   = nxt;
        m_start   = st;
    endtask

    // Drive one cycle of inputs from a negedge, update the model, check after the edge.
    task automatic cycle(input logic uo, lr, bc, bl, input logic [1:0] sel,
                         input logic po, pto, ptw);
        unlock_ok = uo; lock_req = lr; btn_c = bc; btn_l = bl; menu_sel = sel;
        pokemon_over = po; potion_over = pto; potion_win = ptw;
        @(posedge clk);
        model_step(uo, lr, bc, bl, sel, po, pto, ptw);
        #1;
        check_val("state", 32'(state), 32'(m_state));
        check_val("load_progress", 32'(load_progress), 32'(m_prog));
        check_val("game_start", 32'(game_start), 32'(m_start));
        unlock_ok = 1'b0; lock_req = 1'b0; btn_c = 1'b0; btn_l = 1'b0;
        pokemon_over = 1'b0; potion_over = 1'b0; potion_win = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_c(input logic [1:0] sel);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, sel, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        unlock_ok = 1'b0; lock_req = 1'b0; btn_c = 1'b0; btn_l = 1'b0; menu_sel = 2'd0;
        pokemon_over = 1'b0; potion_over = 1'b0; potion_win = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("reset_state", 32'(state), 32'hF);
        check_val("reset_progress", 32'(load_progress), 32'd0);
        check_val("reset_start", 32'(game_start), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Locked ignores btn_c, unlock reaches the menu.
        press_c(2'd1);
        check_val("locked_ignores_c", 32'(state), 32'hF);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_val("unlock_to_menu", 32'(state), 32'h0);

        // Volume has no loading screen.
        press_c(2'd0);
        check_val("volume_direct", 32'(state), 32'h1);
        check_val("volume_start", 32'(game_start), 32'd1);
        idle(1);
        check_val("volume_start_once", 32'(game_start), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        check_val("volume_back", 32'(state), 32'h0);

        // Asynchronous reset in the middle of a loading screen.
        press_c(2'd2);
        idle(5);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrun_rst_state", 32'(state), 32'hF);
        check_val("midrun_rst_progress", 32'(load_progress), 32'd0);
        check_val("midrun_rst_start", 32'(game_start), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Full loading sequence into fruit.
        press_c(2'd2);
        check_val("loading_entry", 32'(state), 32'h6);
        idle(2);
        check_val("loading_step1", 32'(load_progress), 32'd1);
        idle(189);
        check_val("loading_last", 32'(load_progress), 32'd95);
        idle(1);
        check_val("fruit_entry", 32'(state), 32'h4);
        check_val("fruit_progress", 32'(load_progress), 32'd96);
        check_val("fruit_start", 32'(game_start), 32'd1);
        idle(1);
        check_val("fruit_start_once", 32'(game_start), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);

        // Potion: simultaneous win and loss, then timed return.
        press_c(2'd3);
        idle(192);
        check_val("potion_entry", 32'(state), 32'h5);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        check_val("win_precedence", 32'(state), 32'h8);
        idle(9);
        check_val("win_held", 32'(state), 32'h8);
        idle(1);
        check_val("win_timeout", 32'(state), 32'h0);
        check_val("win_timeout_progress", 32'(load_progress), 32'd0);

        // Pokemon over, early exit with btn_c, stray event in menu.
        press_c(2'd1);
        idle(192);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        check_val("poke_over", 32'(state), 32'h3);
        idle(2);
        press_c(2'd0);
        check_val("poke_over_c", 32'(state), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        check_val("stray_event", 32'(state), 32'h0);

        // Lock during loading, then an illegal encoding.
        press_c(2'd2);
        idle(80);
        check_val("loading_40", 32'(load_progress), 32'd40);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_val("lock_abort", 32'(state), 32'hF);
        check_val("lock_abort_progress", 32'(load_progress), 32'd0);
        check_val("lock_abort_start", 32'(game_start), 32'd0);
        force dut.r_state = app_state_e'(4'b1010);
        #1;
        release dut.r_state;
        m_state   = 4'b1010;
        m_elapsed = 0;
        idle(1);
        check_val("illegal_recover", 32'(state), 32'h0);

        // Randomized pulse traffic.
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 14) == 0), ($urandom_range(0, 14) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/app_state_sequencer.md
Name: app_state_sequencer

Overview:
Top-level application controller that generates the 4-bit screen/app state consumed by the final OLED/7-segment output mux. It handles lock/unlock, menu selection, the timed loading screen before each game, game-over and win screens with automatic return to the menu, and a one-cycle start pulse to the selected game. All inputs are single-cycle, debounced, clk-synchronous pulses from the button, password and game blocks.

Parameters:
LOAD_STEP, 1_041_667, clk cycles per loading-bar increment (96 steps, about 1 s at 100 MHz).
HOLD_CYCLES, 300_000_000, clk cycles an over/win screen is held before auto-return to MENU.
CNT_W, 32, width of the shared cycle counter; must hold max(LOAD_STEP, HOLD_CYCLES).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
unlock_ok  in  1  pulse: password accepted
lock_req  in  1  pulse: re-lock the system
btn_c  in  1  pulse: select / confirm
btn_l  in  1  pulse: back to menu
menu_sel  in  2  menu cursor: 0 volume, 1 pokemon, 2 fruit, 3 potion
pokemon_over  in  1  pulse from pokemon game
potion_over  in  1  pulse from potion game: lost
potion_win  in  1  pulse from potion game: won
state  out  4  registered app state to the output mux
load_progress  out  7  loading-bar length in pixels, 0..96
game_start  out  1  one-cycle pulse on entry to VOLUME, POKEMON, FRUIT or POTION

Behaviour:
- Encodings (fixed, shared with the mux): LOCKED 4'b1111, MENU 0000, VOLUME 0001, POKEMON 0010, POKE_OVER 0011, FRUIT 0100, POTION 0101, LOADING 0110, POTION_OVER 0111, POTION_WIN 1000.
- Reset (rst_n low, asynchronous): state=LOCKED, load_progress=0, game_start=0, counter=0, target=MENU.
- All outputs are registered. A pulse sampled at edge N updates state at edge N, visible in cycle N+1.
- Priority each cycle: lock_req > game events > btn_l > btn_c. lock_req in any state other than LOCKED goes to LOCKED.
- LOCKED: unlock_ok goes to MENU. All other inputs are ignored.
- MENU: btn_c with menu_sel=0 goes directly to VOLUME. menu_sel=1/2/3 latches target=POKEMON/FRUIT/POTION and goes to LOADING. menu_sel is sampled only on the btn_c cycle.
- LOADING:
  - Counter counts 0..LOAD_STEP-1. On wrap, load_progress increments.
  - On the wrap where load_progress==95, load_progress becomes 96, state becomes target and game_start pulses.
  - btn_c and btn_l are ignored. lock_req aborts to LOCKED.
- VOLUME, FRUIT: btn_l goes to MENU.
- POKEMON: pokemon_over goes to POKE_OVER. Otherwise btn_l goes to MENU.
- POTION: potion_win goes to POTION_WIN and potion_over goes to POTION_OVER. If both fire in the same cycle, win takes precedence. Otherwise btn_l goes to MENU.
- POKE_OVER, POTION_OVER, POTION_WIN:
  - Counter runs from 0. At HOLD_CYCLES-1, or on btn_c, go to MENU.
  - Game event pulses are ignored.
- Events that do not belong to the current state are ignored, e.g. pokemon_over outside POKEMON.
- Counter clears on every state change and is held at 0 in states without a timer.
- load_progress clears to 0 on entry to LOADING and on any exit to MENU or LOCKED. It holds 96 while a game runs.
- game_start is high for exactly 1 cycle per game entry, and never on entry to MENU, LOCKED or an over/win state.
- Illegal encodings 1001–1110 go to MENU on the next edge with counter=0.

Decomposition:
- Package app_state_pkg:
  - the state localparams (also imported by the final mux);
  - LOAD_STEPS=96;
  - menu_sel codes SEL_VOLUME/SEL_POKEMON/SEL_FRUIT/SEL_POTION.
- Sub-module cycle_timer (clk, rst_n, clr, en, limit → done, count), instantiated once and shared by LOADING and the hold states.

Test Plan:
All scenarios use LOAD_STEP=2 and HOLD_CYCLES=10.
1. rst_n low mid-run → state=1111, load_progress=0, game_start=0 immediately. After release, btn_c alone → stays 1111. unlock_ok → 0000 one cycle later.
2. MENU, menu_sel=2, btn_c → state 0110. load_progress increments every 2 cycles. 192 cycles after entry, state=0100, load_progress=96, game_start high exactly 1 cycle.
3. MENU, menu_sel=0, btn_c → state 0001 next cycle with game_start pulse and no loading. btn_l → 0000.
4. POTION, potion_over and potion_win in the same cycle → 1000. No other input → 0000 after 10 cycles and load_progress=0.
5. POKEMON, pokemon_over → 0011. btn_c on the 3rd cycle → 0000. pokemon_over then pulsed while in MENU → stays 0000.
6. LOADING at load_progress=40, lock_req together with btn_c → 1111, load_progress=0, no game_start. Force illegal state 1010 → 0000 next edge.
